// File: rtl/tanh_scheduler_pkg.sv
// Shared types and constants for the tanh activation-unit scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tanh_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

endpackage

// File: rtl/tanh_scheduler_if.sv
// Requester-side request/response bundle of the tanh scheduler.
// Latency: n/a (wiring only).
// Backpressure: req_valid/req_ready and rsp_valid/rsp_ready handshakes per requester.
// Ports: req_valid/req_data/rsp_ready driven by requesters (master),
//        req_ready/rsp_valid/rsp_data/rsp_err driven by the scheduler (slave).
interface tanh_scheduler_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        rsp_valid;
    logic [N_REQ-1:0]        rsp_ready;
    logic [DATA_W-1:0]       rsp_data;
    logic                    rsp_err;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/tanh_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a grant is consumed.
// Ports: req (requests), ptr (highest-priority index), grant (one-hot),
//        grant_idx (binary index of grant), any (some request present).
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             any
);
    // One extra bit so ptr + k never overflows before the wrap subtraction.
    logic [PTR_W:0]   w_sum;
    logic [PTR_W-1:0] w_idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        w_sum     = '0;
        w_idx     = '0;
        // Offset 0 is the pointer itself; the first hit in offset order wins.
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, ptr} + (PTR_W+1)'(k);
            if (w_sum >= (PTR_W+1)'(N)) begin
                w_sum = w_sum - (PTR_W+1)'(N);
            end
            w_idx = w_sum[PTR_W-1:0];
            if (!any && req[w_idx]) begin
                any          = 1'b1;
                grant[w_idx] = 1'b1;
                grant_idx    = w_idx;
            end
        end
    end
endmodule

// File: rtl/tanh_scheduler.sv
// Shares one HyperBolicTangent unit among N_REQ requesters with round-robin arbitration and a WAIT timeout.
// Latency: accept edge to rsp_valid = 2 cycles + unit latency (TIMEOUT+1 cycles on timeout).
// Backpressure: one operation in flight; no req_ready outside IDLE; RESP holds until the owner's rsp_ready.
// Ports: clk, reset (async active-low), bus (requester bundle, slave side),
//        tanh_x/tanh_reset to the unit, tanh_out/tanh_finished from it, busy (not IDLE).
module tanh_scheduler
    import tanh_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    tanh_scheduler_if.slave   bus,
    output logic [DATA_W-1:0] tanh_x,
    output logic              tanh_reset,
    input  logic [DATA_W-1:0] tanh_out,
    input  logic              tanh_finished,
    output logic              busy
);
    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT);

    state_t            r_state;
    logic [PTR_W-1:0]  r_ptr;
    logic [PTR_W-1:0]  r_owner;
    logic [DATA_W-1:0] r_x;
    logic [DATA_W-1:0] r_res;
    logic              r_err;
    logic [CNT_W-1:0]  r_cnt;

    logic [N_REQ-1:0]  w_grant;
    logic [PTR_W-1:0]  w_grant_idx;
    logic              w_any;

    rr_arbiter #(.N(N_REQ), .PTR_W(PTR_W)) u_arb (
        .req       (bus.req_valid),
        .ptr       (r_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx),
        .any       (w_any)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_x     <= '0;
            r_res   <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_x     <= bus.req_data[w_grant_idx*DATA_W +: DATA_W];
                        r_owner <= w_grant_idx;
                        r_state <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    r_cnt   <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    // Finished is checked first so a result on the last
                    // allowed cycle still beats the timeout.
                    if (tanh_finished) begin
                        r_res   <= tanh_out;
                        r_err   <= 1'b0;
                        r_state <= RESP;
                    end else if (r_cnt == CNT_W'(TIMEOUT-1)) begin
                        r_res   <= DATA_W'(FP_ZERO);
                        r_err   <= 1'b1;
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready[r_owner]) begin
                        r_ptr   <= (r_owner == PTR_W'(N_REQ-1)) ? '0 : r_owner + 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Accept pulse only in IDLE; gated by reset so it is quiet while held in reset.
    assign bus.req_ready = (r_state == IDLE && reset) ? w_grant : '0;
    assign bus.rsp_valid = (r_state == RESP) ? (N_REQ'(1) << r_owner) : '0;
    assign bus.rsp_data  = (r_state == RESP) ? r_res : '0;
    assign bus.rsp_err   = (r_state == RESP) && r_err;

    // The unit is held cleared until the operand has been presented for one cycle.
    assign tanh_reset = (r_state == IDLE) || (r_state == LAUNCH);
    assign tanh_x     = r_x;
    assign busy       = (r_state != IDLE);
endmodule

// File: tb/tb_tanh_scheduler.sv
// Bench for tanh_scheduler with a behavioural stand-in for the tanh unit.
// Latency: n/a.
// Backpressure: exercised via held-low owner rsp_ready and asserted non-owner rsp_ready.
module tb_tanh_scheduler;
    import tanh_sched_pkg::*;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tanh_scheduler_if #(.N_REQ(N), .DATA_W(W)) bus ();

    logic [W-1:0] tanh_x;
    logic [W-1:0] tanh_out;
    logic         tanh_reset;
    logic         tanh_finished;
    logic         busy;

    tanh_scheduler #(.N_REQ(N), .DATA_W(W), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .tanh_x        (tanh_x),
        .tanh_reset    (tanh_reset),
        .tanh_out      (tanh_out),
        .tanh_finished (tanh_finished),
        .busy          (busy)
    );

    // Stand-in unit: cleared while tanh_reset is high, then raises Finished
    // once it has counted u_lat cycles (never, if u_hang).
    int u_lat  = 0;
    bit u_hang = 1'b0;
    int u_cnt  = 0;

    function automatic logic [31:0] unit_fn(input logic [31:0] x);
        if (x == 32'h3F19_999A) return 32'h3F09_6F7B;
        if (x == 32'h4040_0000) return FP_ONE;
        return x ^ 32'hA5C3_0F96;
    endfunction

    always @(posedge clk) begin
        if (tanh_reset) u_cnt <= 0;
        else if (u_cnt < 1000) u_cnt <= u_cnt + 1;
    end
    assign tanh_finished = !u_hang && (u_cnt >= u_lat);
    assign tanh_out      = unit_fn(tanh_x);

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state: priority pointer and operands offered.
    int           m_ptr = 0;
    logic [W-1:0] m_data [N];

    function automatic int rr_pick(input logic [N-1:0] mask, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (mask[(ptr + k) % N]) return (ptr + k) % N;
        end
        return 0;
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // One complete operation. The owner's rsp_ready is left high on return so
    // the next call's first negedge lies just after the completion edge.
    task automatic txn(input logic [N-1:0] mask, input logic [W-1:0] fx, input bit use_fx,
                       input int lat, input bit hang, input int bp);
        int           g;
        int           el;
        int           exp_el;
        logic [W-1:0] x;
        logic [W-1:0] exp_d;
        bit           exp_e;

        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            m_data[i] = use_fx ? fx : W'($urandom);
            bus.req_data[i*W +: W] = m_data[i];
        end
        u_lat = lat;
        u_hang = hang;
        bus.rsp_ready = '0;
        bus.req_valid = mask;
        #1;
        g = rr_pick(mask, m_ptr);
        x = m_data[g];
        chk("idle_busy", busy, 1'b0);
        chk("idle_tanh_reset", tanh_reset, 1'b1);
        chk("grant", bus.req_ready, onehot(g));

        if (!hang && lat <= TO - 1) begin
            exp_d = unit_fn(x); exp_e = 1'b0; exp_el = lat + 2;
        end else begin
            exp_d = '0; exp_e = 1'b1; exp_el = TO + 1;
        end

        @(negedge clk);
        el = 0;
        chk("launch_tanh_reset", tanh_reset, 1'b1);
        chk("launch_tanh_x", tanh_x, x);
        chk("launch_busy", busy, 1'b1);
        while (bus.rsp_valid == '0 && el < 40) begin
            chk("no_ready_in_flight", bus.req_ready, '0);
            if (el >= 1) chk("wait_tanh_reset", tanh_reset, 1'b0);
            @(negedge clk);
            el++;
        end
        chk("rsp_latency", 64'(el), 64'(exp_el));
        chk("rsp_valid", bus.rsp_valid, onehot(g));
        chk("rsp_data", bus.rsp_data, exp_d);
        chk("rsp_err", bus.rsp_err, exp_e);
        chk("resp_tanh_reset", tanh_reset, 1'b0);

        for (int b = 0; b < bp; b++) begin
            bus.rsp_ready = ~onehot(g);
            @(negedge clk);
            chk("bp_rsp_valid", bus.rsp_valid, onehot(g));
            chk("bp_rsp_data", bus.rsp_data, exp_d);
            chk("bp_req_ready", bus.req_ready, '0);
        end
        bus.rsp_ready = onehot(g) | N'($urandom);
        m_ptr = (g + 1) % N;
    endtask

    initial begin
        reset = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.rsp_ready = '0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", bus.req_ready, '0);
        chk("rst_rsp_valid", bus.rsp_valid, '0);
        chk("rst_rsp_data", bus.rsp_data, '0);
        chk("rst_rsp_err", bus.rsp_err, 1'b0);
        chk("rst_tanh_x", tanh_x, '0);
        chk("rst_tanh_reset", tanh_reset, 1'b1);
        chk("rst_busy", busy, 1'b0);
        reset = 1'b1;

        // Directed operands, then pointer steered to 0 for the fairness run.
        txn(4'b0001, 32'h3F19_999A, 1'b1, $urandom_range(0, 5), 1'b0, 0);
        txn(4'b0100, 32'h4040_0000, 1'b1, $urandom_range(0, 5), 1'b0, 0);
        txn(4'b1000, '0, 1'b0, 0, 1'b0, 0);
        repeat (5) txn(4'b1111, '0, 1'b0, $urandom_range(0, 5), 1'b0, 0);

        // Hung unit, then the next requester must still be served.
        txn(4'b0110, '0, 1'b0, 0, 1'b1, 0);
        txn(4'b0110, '0, 1'b0, 2, 1'b0, 0);
        // Finished on the last WAIT cycle beats the timeout; one cycle later loses.
        txn(4'b1111, '0, 1'b0, TO - 1, 1'b0, 0);
        txn(4'b1111, '0, 1'b0, TO, 1'b0, 1);
        // Long backpressure on requester 1.
        txn(4'b0010, '0, 1'b0, $urandom_range(0, 5), 1'b0, 10);

        repeat (20) txn(N'($urandom_range(1, 15)), '0, 1'b0, $urandom_range(0, 9),
                        ($urandom_range(0, 7) == 0), $urandom_range(0, 3));

        // Leave the pointer at 3, then abort an operation mid-WAIT.
        txn(4'b0100, '0, 1'b0, 1, 1'b0, 0);
        @(negedge clk);
        bus.rsp_ready = '0;
        u_lat = 6;
        u_hang = 1'b0;
        bus.req_valid = 4'b0100;
        #1;
        chk("abort_grant", bus.req_ready, 4'b0100);
        repeat (3) @(negedge clk);
        chk("abort_in_wait", busy, 1'b1);
        reset = 1'b0;
        #1;
        chk("mid_rst_req_ready", bus.req_ready, '0);
        chk("mid_rst_rsp_valid", bus.rsp_valid, '0);
        chk("mid_rst_rsp_data", bus.rsp_data, '0);
        chk("mid_rst_rsp_err", bus.rsp_err, 1'b0);
        chk("mid_rst_tanh_x", tanh_x, '0);
        chk("mid_rst_tanh_reset", tanh_reset, 1'b1);
        chk("mid_rst_busy", busy, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        bus.req_valid = '0;
        m_ptr = 0;
        txn(4'b1010, '0, 1'b0, 3, 1'b0, 0);

        @(negedge clk);
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        #1;
        chk("final_idle", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
